hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: issues per-stage enable/flush to the PC, IF/ID, ID/EX, EX/MEM, MEM/WB regs.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_sat_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : hazard_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Sequencer states: running, frozen on a data-memory wait, trapped.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } hz_state_t;

  // Architectural zero register; a load to it never creates a dependency.
  localparam int unsigned REG_X0 = 0;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  // Count up on inc, hold once every bit is set; clear wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl
// Brief  : 5-stage pipeline sequencer. Generates per-stage enable/flush for
//          load-use stalls, EX redirects and data-memory wait states, traps a
//          hung memory with a watchdog and keeps stall/flush perf counters.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_rd_en,
  input  logic              ex_redirect,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_flush,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Wait counter must be able to hold MEM_TIMEOUT.
  localparam int unsigned     WCW       = $clog2(MEM_TIMEOUT + 1);
  // Last wait count still tolerated before the watchdog fires.
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  hz_state_t      state;
  hz_state_t      state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;
  logic           mem_err_nxt;

  logic           mem_stall;
  logic           load_use;
  logic           frozen;

  assign mem_stall = mem_access & ~dmem_ready;

  assign load_use  = ex_mem_rd_en && (ex_rd != REG_AW'(REG_X0)) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

  // The whole pipe holds while an access is outstanding and not yet ready.
  assign frozen = ((state == ST_RUN) && mem_stall) ||
                  ((state == ST_MEM_WAIT) && !dmem_ready);

  // State, watchdog count and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  // Next-state logic and per-stage control, prioritised err > wait > redirect > load-use.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;

    pc_en        = 1'b1;
    pc_redirect  = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;

    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          if (MEM_TIMEOUT <= 1) begin
            state_nxt    = ST_ERR;
            mem_err_nxt  = 1'b1;
            wait_cnt_nxt = '0;
          end else begin
            state_nxt    = ST_MEM_WAIT;
            wait_cnt_nxt = WCW'(1);
          end
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt >= WAIT_LAST) begin
          state_nxt    = ST_ERR;
          mem_err_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (!rst_n) begin
      // Hold every stage and bubble the pipe while reset is asserted.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state == ST_ERR) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
    end else if (frozen) begin
      // MEM/WB bubbles so the frozen MEM instr is not written back twice.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      // Younger instrs in IF and ID are wrong-path; any load-use is moot.
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en & rst_n),
    .clear (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_redirect),
    .clear (1'b0),
    .q     (flush_cnt)
  );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Self-checking bench for hazard_ctrl with a reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;

  // Control vector order: {pc_en, pc_redirect, if_id_en, if_id_flush,
  //                        id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [7:0] V_RESET  = 8'b0001_0101;
  localparam logic [7:0] V_ERR    = 8'b0000_0000;
  localparam logic [7:0] V_FREEZE = 8'b0000_0001;
  localparam logic [7:0] V_REDIR  = 8'b1111_1110;
  localparam logic [7:0] V_LU     = 8'b0000_1110;
  localparam logic [7:0] V_NORMAL = 8'b1010_1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_mem_rd_en, ex_redirect;
  logic        mem_access, dmem_ready;
  logic        pc_en, pc_redirect, if_id_en, if_id_flush;
  logic        id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_err, m_busy;
  int m_consec, m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_AW(5), .CNT_W(32), .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_rd_en(ex_mem_rd_en), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_redirect(pc_redirect),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Does the ID instr read the register the EX load produces?
  function automatic bit depends();
    logic [4:0] srcs [2];
    bit         used [2];
    srcs[0] = id_rs1; used[0] = id_rs1_used;
    srcs[1] = id_rs2; used[1] = id_rs2_used;
    if (!ex_mem_rd_en || ex_rd == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (used[k] && srcs[k] == ex_rd) return 1'b1;
    return 1'b0;
  endfunction

  // Is the pipeline held by memory this cycle?
  function automatic bit model_frozen();
    if (m_busy) return !dmem_ready;
    return mem_access && !dmem_ready;
  endfunction

  function automatic logic [7:0] model_ctrl();
    if (!rst_n)         return V_RESET;
    if (m_err)          return V_ERR;
    if (model_frozen()) return V_FREEZE;
    if (ex_redirect)    return V_REDIR;
    if (depends())      return V_LU;
    return V_NORMAL;
  endfunction

  // Model bookkeeping at each active edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err = 0; m_busy = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    end else begin
      logic [7:0] v;
      v = model_ctrl();
      if (!v[7]) m_stall++;
      if (v[6])  m_flush++;
      if (!m_err) begin
        if (model_frozen()) begin
          m_busy = 1;
          m_consec++;
          if (m_consec >= TIMEOUT) m_err = 1;
        end else begin
          m_busy = 0;
          m_consec = 0;
        end
      end
    end
  end

  // Compare process: outputs checked mid-cycle, away from the active edge
  always @(negedge clk) begin
    check("ctrl", {24'd0, pc_en, pc_redirect, if_id_en, if_id_flush,
                   id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush},
          {24'd0, model_ctrl()});
    check("mem_err",   {31'd0, mem_err}, {31'd0, m_err});
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
  end

  // Drive one cycle of inputs; returns just after the mid-cycle compare.
  task automatic apply(input bit ma, input bit dr, input bit redir, input bit ld,
                       input logic [4:0] rd, input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2);
    mem_access = ma; dmem_ready = dr; ex_redirect = redir; ex_mem_rd_en = ld;
    ex_rd = rd; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    mem_access = 0; dmem_ready = 1; ex_redirect = 0; ex_mem_rd_en = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    @(negedge clk); #1;
    check("reset_ctrl", {24'd0, pc_en, pc_redirect, if_id_en, if_id_flush,
                         id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}, {24'd0, V_RESET});
    rst_n = 1'b1;

    idle();
    check("normal_pc_en", {31'd0, pc_en}, 32'd1);

    // 1: lw x5 in EX, ID reads x5 -> one bubble
    apply(0, 1, 0, 1, 5'd5, 5'd5, 1, 5'd3, 1);
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    idle();
    check("lu_release", {31'd0, pc_en}, 32'd1);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    // rs2 path dependency also stalls
    apply(0, 1, 0, 1, 5'd7, 5'd1, 1, 5'd7, 1);
    check("lu_rs2_pc_en", {31'd0, pc_en}, 32'd0);
    // unused operand matching rd does not stall
    apply(0, 1, 0, 1, 5'd7, 5'd7, 0, 5'd2, 1);
    check("lu_unused", {31'd0, pc_en}, 32'd1);

    // 2: lw x0 never stalls
    apply(0, 1, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    check("x0_pc_en", {31'd0, pc_en}, 32'd1);
    idle();
    check("x0_stall_cnt", stall_cnt, 32'd2);

    // 3: three frozen cycles then release
    repeat (3) begin
      apply(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
      check("wait_pc_en", {31'd0, pc_en}, 32'd0);
      check("wait_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd1);
    end
    apply(1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check("wait_release", {31'd0, pc_en}, 32'd1);
    check("wait_flush_cnt", flush_cnt, 32'd0);
    check("wait_stall_cnt", stall_cnt, 32'd5);

    // 4: redirect overrides load-use
    apply(0, 1, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0);
    check("redir_ctrl", {24'd0, pc_en, pc_redirect, if_id_en, if_id_flush,
                         id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}, {24'd0, V_REDIR});
    idle();
    check("redir_flush_cnt", flush_cnt, 32'd1);

    // 5: redirect deferred through a wait
    apply(1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check("defer_redir_a", {31'd0, pc_redirect}, 32'd0);
    apply(1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check("defer_redir_b", {31'd0, pc_redirect}, 32'd0);
    apply(1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check("defer_redir_fire", {31'd0, pc_redirect}, 32'd1);
    idle();
    check("defer_flush_cnt", flush_cnt, 32'd2);

    // 6a: reset mid-wait abandons the access
    apply(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    apply(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_wb_flush", {31'd0, mem_wb_flush}, 32'd1);
    check("rst_mid_stall_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check("rst_mid_run", {31'd0, pc_en}, 32'd1);

    // 6b: watchdog after TIMEOUT consecutive wait cycles
    repeat (TIMEOUT) apply(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle();
    check("err_mem_err", {31'd0, mem_err}, 32'd1);
    check("err_ctrl", {24'd0, pc_en, pc_redirect, if_id_en, if_id_flush,
                       id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}, {24'd0, V_ERR});
    apply(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check("err_no_redir", {31'd0, pc_redirect}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("err_async_clear", {31'd0, mem_err}, 32'd0);
    rst_n = 1'b1;
    idle();
    check("err_recover", {31'd0, pc_en}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
